// File: rtl/layer1_conv_sequencer_if.sv
// layer1_conv_sequencer_if: loader/MAC/output-memory handshake bundle for the Layer-1 compute controller
interface layer1_conv_sequencer_if;
  logic start;
  logic ldDone;
  logic ldAllDone;
  logic ldBuf;
  logic [1:0] rdI;
  logic [1:0] rdJ;
  logic accClr;
  logic accEn;
  logic outWrEn;
  logic [7:0] outAddr;
  logic busy;
  logic done;
  modport master (
    input start, ldDone, ldAllDone,
    output ldBuf, rdI, rdJ, accClr, accEn, outWrEn, outAddr, busy, done
  );
  modport slave (
    output start, ldDone, ldAllDone,
    input ldBuf, rdI, rdJ, accClr, accEn, outWrEn, outAddr, busy, done
  );
endinterface

// File: rtl/layer1_conv_sequencer.sv
// layer1_conv_sequencer: sequences window load, 16 MAC reads, pipeline drain, result write and next-window request
module layer1_conv_sequencer #(
  parameter int KSIZE = 4,
  parameter int OUT_DIM = 13,
  parameter int MAC_LAT = 2
) (
  input logic clk,
  input logic rst,
  layer1_conv_sequencer_if.master b
);
  localparam int NK = KSIZE * KSIZE;
  localparam int NPOS = OUT_DIM * OUT_DIM;
  localparam int KW = $clog2(NK);
  localparam int DW = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_LD, CLEAR, MAC, DRAIN, WRITE, REQ, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [DW-1:0] d;
  logic [7:0] pos;
  logic guard;
  logic [MAC_LAT-1:0] acc_pipe;
  logic unused_ld_all;
  // ldAllDone is informational; termination comes from the position count
  assign unused_ld_all = b.ldAllDone;
  assign b.accEn = acc_pipe[MAC_LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      d <= '0;
      pos <= '0;
      guard <= 1'b0;
      acc_pipe <= '0;
      b.accClr <= 1'b0;
      b.outWrEn <= 1'b0;
      b.ldBuf <= 1'b0;
      b.rdI <= '0;
      b.rdJ <= '0;
      b.outAddr <= '0;
      b.busy <= 1'b0;
      b.done <= 1'b0;
    end else begin
      acc_pipe <= MAC_LAT'({acc_pipe, state == MAC});
      b.accClr <= 1'b0;
      b.outWrEn <= 1'b0;
      b.ldBuf <= 1'b0;
      b.rdI <= '0;
      b.rdJ <= '0;
      b.outAddr <= '0;
      case (state)
        IDLE: if (b.start) begin
          state <= WAIT_LD;
          b.busy <= 1'b1;
          pos <= '0;
          guard <= 1'b0;
        end
        // guard masks the ldDone still held from the window just consumed
        WAIT_LD: if (guard) guard <= 1'b0;
        else if (b.ldDone) begin
          state <= CLEAR;
          b.accClr <= 1'b1;
        end
        CLEAR: begin
          k <= '0;
          state <= MAC;
        end
        MAC: if (k == KW'(NK - 1)) begin
          state <= DRAIN;
          d <= '0;
        end else begin
          k <= k + 1'b1;
          b.rdI <= 2'((32'(k) + 1) / KSIZE);
          b.rdJ <= 2'((32'(k) + 1) % KSIZE);
        end
        DRAIN: if (d == DW'(MAC_LAT - 1)) begin
          state <= WRITE;
          b.outWrEn <= 1'b1;
          b.outAddr <= pos;
        end else d <= d + 1'b1;
        WRITE: if (pos == 8'(NPOS - 1)) begin
          state <= DONE;
          b.busy <= 1'b0;
          b.done <= 1'b1;
        end else begin
          state <= REQ;
          b.ldBuf <= 1'b1;
        end
        REQ: begin
          pos <= pos + 1'b1;
          guard <= 1'b1;
          state <= WAIT_LD;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/layer1_conv_sequencer.md
Name: layer1_conv_sequencer

Overview:
- Compute-phase controller for the Layer-1 convolution datapath.
- Waits for the window/filter loader to report a loaded 4x4 window, then sequences 16 MAC read cycles into 4 parallel filter accumulators.
- Drains the MAC pipeline, writes the 4 results to output memory, then requests the next window from the loader.
- Runs until all OUT_DIM x OUT_DIM window positions are processed.

Parameters:
- KSIZE, 4, kernel/window side; one MAC step per window element (KSIZE*KSIZE steps).
- OUT_DIM, 13, output feature-map side; window positions = OUT_DIM*OUT_DIM.
- MAC_LAT, 2, cycles from read index issue to that product being valid at the accumulator input (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a layer pass; ignored unless in IDLE.
- ldDone  input  1  loader holds high while a loaded window is ready.
- ldAllDone  input  1  loader has loaded its final window.
- ldBuf  output  1  one-cycle pulse requesting the loader fetch the next window.
- rdI  output  2  buffer/filter row index for the current MAC step.
- rdJ  output  2  buffer/filter column index for the current MAC step.
- accClr  output  1  clear all 4 filter accumulators.
- accEn  output  1  accumulate the product currently at accumulator input.
- outWrEn  output  1  write the 4 accumulator values to output memory.
- outAddr  output  8  output position index = row*OUT_DIM + col.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values: every output 0; state IDLE; step counter k=0; position pos=0; guard=0; accEn pipeline cleared.
- rst during any state returns to IDLE at the next edge and discards partial accumulation; no outWrEn or ldBuf is issued on that edge.

States:
- IDLE: start=1 -> WAIT_LD.
- WAIT_LD: if guard=1, clear guard and stay. Otherwise ldDone=1 -> CLEAR. guard is set on exit from REQ, so a stale ldDone is never sampled in the first cycle after a request.
- CLEAR: accClr=1 for 1 cycle; k<=0 -> MAC.
- MAC: issues rdI=k[3:2], rdJ=k[1:0] and k++. After k=15 is issued, go to DRAIN. Exactly 16 cycles.
- DRAIN: MAC_LAT cycles, tracked by a drain counter, then -> WRITE.
- WRITE: outWrEn=1, outAddr=pos for 1 cycle. If pos=OUT_DIM*OUT_DIM-1 -> DONE, else -> REQ.
- REQ: ldBuf=1 for 1 cycle; pos++ -> WAIT_LD.
- DONE: done=1, held until rst. start is ignored.

Arithmetic and timing:
- accEn is the MAC-issue valid delayed by MAC_LAT through a shift register. It is high exactly 16 cycles per window, the last one being the final DRAIN cycle.
- accClr never overlaps accEn.
- rdI/rdJ are 0 outside MAC.
- pos is 8-bit. Max 168 at default parameters; no wrap is required.

Per-window latency:
- Non-final window: 1 + 16 + MAC_LAT + 1 + 1 cycles from ldDone sampled to ldBuf. This is 21 cycles at MAC_LAT=2.
- Final window: REQ is omitted.

Boundary conditions:
- ldAllDone is informational only. If ldAllDone=1 while pos is less than final, the sequencer still waits for ldDone; it never terminates early.
- ldDone dropping during MAC/DRAIN is ignored.

Test Plan:
- Reset then idle: assert rst 3 cycles, hold ldDone=1 without start -> all outputs 0, state stays IDLE, no accClr.
- Single window: start, ldDone=1 two cycles later -> accClr one cycle; rdI/rdJ sweep (0,0),(0,1)..(3,3) over 16 consecutive cycles; accEn 16 cycles starting 2 cycles after the first issue; outWrEn with outAddr=0; ldBuf pulse the next cycle. ldDone to ldBuf = 21 cycles.
- Stale-ldDone guard: keep ldDone=1 through REQ and the following cycle -> CLEAR is not entered until the second WAIT_LD cycle; exactly one window is processed per ldBuf.
- Full pass with a model loader (ldDone 17 cycles after each ldBuf) -> 169 outWrEn pulses with outAddr 0..168 in order and 168 ldBuf pulses; done=1 after outAddr=168 write; no ldBuf after the last write.
- Reset mid-MAC: rst at MAC step k=7 -> IDLE next cycle; no outWrEn; accEn returns to 0 within 1 cycle. A new start reprocesses from pos=0.
- start while busy: pulse start during DRAIN and again in DONE -> no state change, outAddr sequence unaffected.
